serial_8bit_subtractor: RTL and testbench
=========================================

Name: serial_8bit_subtractor

Overview:
Bit-serial subtractor that computes diff = a - b - bin, one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the inverse-operation companion to the combinational ripple-carry adder in the datapath library. It trades WIDTH cycles of latency for one-bit logic. Operands enter through a valid/ready handshake and the result leaves through another.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands a, b, bin are valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  diff, bout, ovf are valid
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow-out; 1 when unsigned a < b + bin
ovf  output  1  signed (two's complement) overflow

Behaviour:
- Reset is synchronous and active-high.
- While rst is high at a rising edge: state goes to IDLE; out_valid, diff, bout, ovf, bit counter and shift registers clear to 0.
- in_ready is decoded from state, so it is 1 from the first cycle after reset.
- rst overrides all other inputs, including mid-RUN and during DONE. Any in-flight result is discarded and never presented.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid && in_ready at edge T0, latch a, b, bin into the shift registers and borrow register. Clear the counter. Go to RUN.
  - RUN: in_ready=0. Each edge processes bit k (k=0..WIDTH-1):
    - d = a_k ^ b_k ^ br
    - br' = (~a_k & b_k) | (~a_k & br) | (b_k & br)
    - d shifts into diff from the MSB side; the a and b registers shift right.
    - After the edge that processes bit WIDTH-1 (edge T0+WIDTH), go to DONE.
  - DONE: out_valid=1. diff holds the full result, bout = final br, ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
    - Keep the original a[MSB] and b[MSB] in a dedicated register for the ovf computation.
    - On out_valid && out_ready, go to IDLE.
    - Outputs hold stable and unchanged while out_ready=0, for any number of cycles.
- Latency: out_valid first goes high in the cycle after edge T0+WIDTH, i.e. exactly WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum. There is no overlap: in_ready=0 from RUN entry until the DONE handshake completes.
- On the DONE→IDLE edge, out_valid drops to 0. diff, bout and ovf keep their values; only out_valid qualifies them.
- in_valid while not IDLE is ignored. a, b and bin may change freely after acceptance with no effect on the result.
- out_ready high in IDLE or RUN has no effect.
- Wrap-around: diff is modulo 2^WIDTH; there is no saturation.
- bin=1 with a=0, b=all-ones gives diff=0, bout=1.

Decomposition:
- Shared package (sub_pkg): typedef enum state_t {IDLE, RUN, DONE}; localparam CNT_W = $clog2(WIDTH).
- One sub-module, full_subtractor (a, b, bin → d, bout). It is purely combinational and mirrors the existing full_adder cell; instantiate it once.

Test Plan:
1. a=0x50, b=0x20, bin=0, out_ready=1 → out_valid high exactly 8 cycles after accept; diff=0x30, bout=0, ovf=0; in_ready low during RUN/DONE.
2. a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. Then a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1.
3. bin=1: a=0x10, b=0x0F → diff=0x00, bout=0. Then a=0x00, b=0xFF → diff=0x00, bout=1, ovf=0.
4. Backpressure: out_ready=0 for 5 cycles after out_valid rises, with a and b toggling and in_valid held high → diff, bout, ovf, out_valid stable; no new accept. out_ready=1 → IDLE next cycle, then the pending in_valid is accepted.
5. Reset mid-operation: accept a=0x7F, b=0x80; assert rst at cycle 4 of RUN → next cycle state IDLE, out_valid=0, diff=0, in_ready=1; a fresh op a=0x05, b=0x03 → diff=0x02.
6. Random: 1000 random a, b, bin with random out_ready stalls → diff == (a-b-bin) mod 256, bout and ovf match the reference model; out_valid never asserts without a prior accept.

Source files
------------

// File: rtl/serial_8bit_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter width.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/serial_8bit_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_8bit_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/serial_8bit_subtractor_fs.sv
// One-bit full subtractor cell, the borrow counterpart of the full_adder cell.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_8bit_subtractor.sv
// Bit-serial a - b - bin, LSB first through one full-subtractor cell, with
// valid/ready handshakes on operands and result.
module serial_8bit_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_8bit_subtractor_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       msb_r;
    logic             bout_r;
    logic             ovf_r;
    logic             out_valid_r;
    logic             d_s;
    logic             bo_s;
    logic             accept_s;
    logic             last_s;

    full_subtractor u_fs (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (bo_s)
    );

    assign accept_s = bus.in_valid && (state_r == IDLE);
    assign last_s   = (state_r == RUN) && (cnt_r == LAST_BIT);

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Operand shifting, borrow chain and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            diff_r      <= {WIDTH{1'b0}};
            br_r        <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            msb_r       <= 2'b00;
            bout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        br_r  <= bus.bin;
                        cnt_r <= {CW{1'b0}};
                        // Operand sign bits are shifted out, so keep them for ovf.
                        msb_r <= {bus.a[WIDTH-1], bus.b[WIDTH-1]};
                    end
                end
                RUN: begin
                    diff_r <= {d_s, diff_r[WIDTH-1:1]};
                    a_r    <= {1'b0, a_r[WIDTH-1:1]};
                    b_r    <= {1'b0, b_r[WIDTH-1:1]};
                    br_r   <= bo_s;
                    cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        out_valid_r <= 1'b1;
                        bout_r      <= bo_s;
                        ovf_r       <= (msb_r[1] != msb_r[0]) && (d_s != msb_r[1]);
                    end
                end
                DONE: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_serial_8bit_subtractor.sv
// Scoreboard bench for serial_8bit_subtractor: reset, arithmetic corners,
// backpressure, mid-run reset and randomized traffic.
module tb_serial_8bit_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   orphan_cnt = 0;
    bit   in_flight = 1'b0;
    res_t sb_q[$];

    serial_8bit_subtractor_if #(.WIDTH(8)) bus ();

    serial_8bit_subtractor #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst)                                in_flight <= 1'b0;
        else if (bus.in_valid && bus.in_ready)  in_flight <= 1'b1;
        else if (bus.out_valid && bus.out_ready) in_flight <= 1'b0;
    end

    always @(negedge clk) begin
        if (bus.out_valid && !in_flight) orphan_cnt++;
    end

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] f;
        res_t r;
        f    = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        r.d  = f[7:0];
        r.bo = f[8];
        r.ov = (a[7] != b[7]) && (r.d[7] != a[7]);
        return r;
    endfunction

    // Drives one operation; called at #1 after a rising edge, returns likewise.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input int stall, input bit hold, output res_t got, output int lat,
                          output bit stable_ok, output bit ready_leak, output bit tmo);
        int k;
        tmo = 1'b0; stable_ok = 1'b1; ready_leak = 1'b0; lat = 0; got = '0;
        sb_q.push_back(model(ta, tb, tbin));
        bus.a = ta; bus.b = tb; bus.bin = tbin; bus.in_valid = 1'b1;
        bus.out_ready = (stall == 0);
        k = 0;
        while (!bus.in_ready && k < 50) begin @(posedge clk); #1; k++; end
        if (!bus.in_ready) begin tmo = 1'b1; bus.in_valid = 1'b0; return; end
        @(posedge clk); #1;
        bus.in_valid = hold;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) ready_leak = 1'b1;
            @(posedge clk); #1; lat++;
            if (hold) begin bus.a = 8'($urandom); bus.b = 8'($urandom); bus.bin = 1'($urandom); end
        end
        if (!bus.out_valid) begin tmo = 1'b1; return; end
        got = {bus.diff, bus.bout, bus.ovf};
        for (int i = 0; i < stall; i++) begin
            if (bus.in_ready) ready_leak = 1'b1;
            if (!bus.out_valid || {bus.diff, bus.bout, bus.ovf} !== got) stable_ok = 1'b0;
            @(posedge clk); #1;
            if (hold) begin bus.a = 8'($urandom); bus.b = 8'($urandom); bus.bin = 1'($urandom); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.bin = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.out_valid, bus.diff, bus.bout, bus.ovf} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b diff=%h bout=%b ovf=%b, want all 0",
                     bus.out_valid, bus.diff, bus.bout, bus.ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        res_t got, exp;
        int lat; bit st, leak, tmo;
        run_op(8'h50, 8'h20, 1'b0, 0, 1'b0, got, lat, st, leak, tmo);
        exp = sb_q.pop_front();
        vectors++;
        if (tmo || lat != 8) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d (timeout=%b), want 8", lat, tmo);
        end
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL basic_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                     got.d, got.bo, got.ov, exp.d, exp.bo, exp.ov);
        end
        vectors++;
        if (leak) begin
            miscompares++;
            $display("FAIL basic_in_ready: got in_ready=1 during RUN/DONE, want 0");
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== 8'h30) begin
            miscompares++;
            $display("FAIL basic_after_hs: got valid=%b ready=%b diff=%h, want 0 1 30",
                     bus.out_valid, bus.in_ready, bus.diff);
        end
    endtask

    task automatic test_corners();
        logic [16:0] tbl [4];
        res_t got, exp;
        int lat; bit st, leak, tmo;
        tbl[0] = {8'h00, 8'h01, 1'b0};
        tbl[1] = {8'h80, 8'h01, 1'b0};
        tbl[2] = {8'h10, 8'h0F, 1'b1};
        tbl[3] = {8'h00, 8'hFF, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i][16:9], tbl[i][8:1], tbl[i][0], 0, 1'b0, got, lat, st, leak, tmo);
            exp = sb_q.pop_front();
            vectors++;
            if (tmo || got !== exp) begin
                miscompares++;
                $display("FAIL corner_%0d: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                         i, got.d, got.bo, got.ov, exp.d, exp.bo, exp.ov);
            end
        end
    endtask

    task automatic test_backpressure();
        res_t got, exp;
        int lat; bit st, leak, tmo;
        run_op(8'h33, 8'h44, 1'b1, 5, 1'b1, got, lat, st, leak, tmo);
        exp = sb_q.pop_front();
        vectors++;
        if (tmo || got !== exp) begin
            miscompares++;
            $display("FAIL bp_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                     got.d, got.bo, got.ov, exp.d, exp.bo, exp.ov);
        end
        vectors++;
        if (!st || leak) begin
            miscompares++;
            $display("FAIL bp_stable: got stable=%b ready_leak=%b, want 1 0", st, leak);
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got valid=%b ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        run_op(8'hA5, 8'h5A, 1'b0, 0, 1'b0, got, lat, st, leak, tmo);
        exp = sb_q.pop_front();
        vectors++;
        if (tmo || lat != 8 || got !== exp) begin
            miscompares++;
            $display("FAIL bp_pending: got diff=%h lat=%0d, want diff=%h lat=8", got.d, lat, exp.d);
        end
    endtask

    task automatic test_reset_mid();
        res_t got, exp;
        int lat; bit st, leak, tmo, seen;
        bus.a = 8'h7F; bus.b = 8'h80; bus.bin = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.diff !== 8'h00 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_state: got valid=%b diff=%h ready=%b, want 0 00 1",
                     bus.out_valid, bus.diff, bus.in_ready);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL midrst_stale: got out_valid=1 after reset, want 0");
        end
        run_op(8'h05, 8'h03, 1'b0, 0, 1'b0, got, lat, st, leak, tmo);
        exp = sb_q.pop_front();
        vectors++;
        if (tmo || got !== exp) begin
            miscompares++;
            $display("FAIL midrst_fresh: got diff=%h, want %h", got.d, exp.d);
        end
    endtask

    task automatic test_random();
        res_t got, exp;
        int lat; bit st, leak, tmo;
        logic [7:0] ra, rb;
        logic rbin;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            run_op(ra, rb, rbin, int'($urandom_range(0, 3)), 1'b0, got, lat, st, leak, tmo);
            exp = sb_q.pop_front();
            vectors++;
            if (tmo || got !== exp || !st || lat != 8) begin
                miscompares++;
                $display("FAIL rand_%0d a=%h b=%h bin=%b: got diff=%h bout=%b ovf=%b lat=%0d stable=%b, want diff=%h bout=%b ovf=%b lat=8",
                         i, ra, rb, rbin, got.d, got.bo, got.ov, lat, st, exp.d, exp.bo, exp.ov);
            end
        end
        vectors++;
        if (orphan_cnt !== 0) begin
            miscompares++;
            $display("FAIL orphan_valid: got %0d cycles of out_valid without accept, want 0", orphan_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
